// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
// Operation codes and FSM state encodings used by muldiv_seq and muldiv_step.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULU = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVU = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 2*WIDTH+1 accumulator: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               is_div,
    input  logic [2*WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   acc_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-2:0] quo_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum     = '0;
        rem_sh  = '0;
        quo_sh  = '0;
        diff    = '0;
        acc_out = acc_in;
        if (is_div) begin
            // Remainder lives in the upper half, quotient bits shift in at bit 0.
            rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
            quo_sh = acc_in[WIDTH-2:0];
            diff   = {1'b0, rem_sh} - {2'b00, operand};
            if (diff[WIDTH+1])
                acc_out = {rem_sh, quo_sh, 1'b0};
            else
                acc_out = {diff[WIDTH:0], quo_sh, 1'b1};
        end else begin
            sum     = acc_in[2*WIDTH:WIDTH] + (acc_in[0] ? {1'b0, operand} : '0);
            acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed/unsigned multiplier and divider: one bit per clock,
// operand magnitudes in, sign correction and flag generation on the way out.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] S,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             DZ
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    op_t              op_q;
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_step;
    logic [WIDTH-1:0] mag_s;
    logic             sign_r, sign_s;
    logic [CNT_W-1:0] cnt;
    logic             done_pend;

    logic             in_signed, in_neg_r, in_neg_s;
    logic [WIDTH-1:0] in_mag_r, in_mag_s;

    logic             is_div, op_signed, flip, div_zero, div_ovf;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic             nxt_n, nxt_z, nxt_v, nxt_dz;

    assign in_signed = ~op[0];
    assign in_neg_r  = in_signed & R[WIDTH-1];
    assign in_neg_s  = in_signed & S[WIDTH-1];
    assign in_mag_r  = in_neg_r ? -R : R;
    assign in_mag_s  = in_neg_s ? -S : S;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign op_signed = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign busy      = (state == ST_CALC) || (state == ST_FIX);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .operand (mag_s),
        .acc_out (acc_step)
    );

    assign flip     = op_signed && (sign_r != sign_s);
    assign prod_fix = flip ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    assign quo_fix  = flip ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = (op_signed && sign_r) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign div_zero = (mag_s == '0);
    assign div_ovf  = op_signed && sign_r && sign_s && (mag_s == ONE) && (acc[WIDTH-1:0] == MOST_NEG);

    always_comb begin
        nxt_hi = '0;
        nxt_lo = '0;
        nxt_v  = 1'b0;
        nxt_dz = 1'b0;
        nxt_z  = 1'b0;
        if (!is_div) begin
            nxt_hi = prod_fix[2*WIDTH-1:WIDTH];
            nxt_lo = prod_fix[WIDTH-1:0];
            nxt_z  = (prod_fix == '0);
            nxt_v  = op_signed ? (nxt_hi != {WIDTH{nxt_lo[WIDTH-1]}}) : (nxt_hi != '0);
        end else if (div_zero) begin
            // A zero divisor never restores, so the remainder is the
            // dividend magnitude; re-signing it reproduces R exactly.
            nxt_hi = rem_fix;
            nxt_lo = '1;
            nxt_dz = 1'b1;
        end else begin
            nxt_hi = rem_fix;
            nxt_lo = quo_fix;
            nxt_z  = (quo_fix == '0);
            nxt_v  = div_ovf;
        end
        nxt_n = op_signed & (is_div ? nxt_lo[WIDTH-1] : nxt_hi[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_MUL;
            acc       <= '0;
            mag_s     <= '0;
            sign_r    <= 1'b0;
            sign_s    <= 1'b0;
            cnt       <= '0;
            done_pend <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            N         <= 1'b0;
            Z         <= 1'b0;
            V         <= 1'b0;
            DZ        <= 1'b0;
        end else begin
            done      <= done_pend;
            done_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op_t'(op);
                        sign_r <= in_neg_r;
                        sign_s <= in_neg_s;
                        mag_s  <= in_mag_s;
                        acc    <= {{(WIDTH+1){1'b0}}, in_mag_r};
                        cnt    <= '0;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    hi        <= nxt_hi;
                    lo        <= nxt_lo;
                    N         <= nxt_n;
                    Z         <= nxt_z;
                    V         <= nxt_v;
                    DZ        <= nxt_dz;
                    cnt       <= '0;
                    done_pend <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq at WIDTH=64: directed vectors push expected
// results, a negedge monitor pops and compares whenever done pulses.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 64;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MN   = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] R, S;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic         N, Z, V, DZ;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic [3:0]  flags;
        int unsigned start_edge;
        int          id;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          id_next = 0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .R       (R),
        .S       (S),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .N       (N),
        .Z       (Z),
        .V       (V),
        .DZ      (DZ)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("op%0d_hi", mon_e.id), hi, mon_e.hi);
                check($sformatf("op%0d_lo", mon_e.id), lo, mon_e.lo);
                check($sformatf("op%0d_flags_NZVDZ", mon_e.id), 64'({N, Z, V, DZ}), 64'(mon_e.flags));
                check($sformatf("op%0d_latency", mon_e.id), 64'(cyc - mon_e.start_edge), 64'(W + 2));
            end
        end
    end

    // Called at a negedge; returns just after the sampling posedge.
    task automatic issue(input logic [1:0] o, input logic [63:0] r, input logic [63:0] s,
                         input logic [63:0] eh, input logic [63:0] el, input logic [3:0] ef,
                         input bit push);
        exp_t e;
        start = 1'b1; op = o; R = r; S = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.hi = eh; e.lo = el; e.flags = ef; e.start_edge = cyc; e.id = id_next;
            id_next++;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            $display("FAIL wait_done: got no done within 200 cycles, expected done");
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [63:0] r, input logic [63:0] s,
                       input logic [63:0] eh, input logic [63:0] el, input logic [3:0] ef);
        @(negedge clk);
        issue(o, r, s, eh, el, ef, 1'b1);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'b00; R = '0; S = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi ^ lo}, 64'd0);
        check("rst_hi", hi, 64'd0);
        check("rst_flags", 64'({N, Z, V, DZ}), 64'd0);
        reset_n = 1'b1;

        // {N,Z,V,DZ}
        run(OP_MUL,  64'hFFFF_FFFF_FFFF_FFFD, 64'd7, ALL1, 64'hFFFF_FFFF_FFFF_FFEB, 4'b1000);
        run(OP_MULU, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 4'b0010);
        run(OP_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL1, 64'hFFFF_FFFF_FFFF_FFFD, 4'b1000);
        run(OP_DIVU, 64'd100, 64'd7, 64'd2, 64'd14, 4'b0000);
        run(OP_DIVU, 64'd5, 64'd0, 64'd5, ALL1, 4'b0001);
        run(OP_DIV,  MN, ALL1, 64'd0, MN, 4'b1010);
        run(OP_MUL,  64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0, 4'b0100);
        run(OP_MUL,  64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 64'd0, 4'b0010);
        run(OP_DIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 4'b1000);
        run(OP_DIV,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, ALL1, 4'b1001);
        run(OP_DIVU, 64'd3, 64'd10, 64'd3, 64'd0, 4'b0100);

        // Start while busy must be ignored, operands may change mid-flight.
        @(negedge clk);
        issue(OP_MULU, 64'd6, 64'd7, 64'd0, 64'd42, 4'b0000, 1'b1);
        repeat (20) @(negedge clk);
        issue(OP_DIVU, 64'd100, 64'd3, '0, '0, 4'b0000, 1'b0);
        wait_done();

        // Reset mid-CALC, after an ignored second start.
        @(negedge clk);
        issue(OP_DIV, 64'd100, 64'd7, '0, '0, 4'b0000, 1'b0);
        repeat (19) @(negedge clk);
        issue(OP_MUL, 64'd9, 64'd9, '0, '0, 4'b0000, 1'b0);
        check("busy_mid_calc", 64'(busy), 64'd1);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", hi, 64'd0);
        check("midrst_lo", lo, 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run(OP_MUL, 64'd2, 64'd3, 64'd0, 64'd6, 4'b0000);

        // Back-to-back: new start in the done cycle of the previous op.
        run(OP_DIVU, 64'd100, 64'd7, 64'd2, 64'd14, 4'b0000);
        issue(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, ALL1, 64'hFFFF_FFFF_FFFF_FFEB, 4'b1000, 1'b1);
        repeat (60) @(negedge clk);
        check("b2b_hold_hi", hi, 64'd2);
        check("b2b_hold_lo", lo, 64'd14);
        wait_done();

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the operand width in bits; legal values are even and at least 8.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, meaning the iteration counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 2 bits: 00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU.
REQ-007 The block SHALL have ports R and S, input, WIDTH bits each: multiplicand/multiplier, or dividend (R) and divisor (S).
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking hi/lo/flags valid.
REQ-010 The block SHALL have ports hi and lo, output, WIDTH bits each: product MSW/LSW, or remainder (hi) and quotient (lo).
REQ-011 The block SHALL have ports N, Z, V and DZ, output, 1 bit each: negative, zero, overflow and divide-by-zero flags.

Function
REQ-012 The state machine SHALL have states IDLE, CALC and FIX; on the edge that samples start=1 in IDLE it SHALL move IDLE->CALC and register op, |R|, |S| and the operand signs.
REQ-013 For unsigned ops, magnitudes SHALL equal the raw operands; signed ops SHALL two's-complement negative operands, and the most-negative value SHALL be kept as its unsigned magnitude.
REQ-014 CALC SHALL perform exactly one radix-2 step per clock for WIDTH clocks, then go to FIX.
REQ-015 The MUL step SHALL be shift-add on a 2*WIDTH+1-bit accumulator so the carry is kept.
REQ-016 The DIV step SHALL be restoring shift-subtract: the trial subtract is kept when non-negative and the quotient bit SHALL be 1, otherwise 0.
REQ-017 FIX SHALL apply sign correction and load hi/lo/flags; the state SHALL then return to IDLE, with done=1 for exactly the following cycle.
REQ-018 done SHALL assert WIDTH+2 clocks after the edge that sampled start, for every op, divide-by-zero included.
REQ-019 busy SHALL be 1 in CALC and FIX, else 0; start while busy SHALL be ignored; start in the done cycle SHALL be accepted.
REQ-020 hi/lo/flags SHALL hold their values until the next FIX.
REQ-021 For signed MUL, the 2W product SHALL be negated when the signs differ; V SHALL be 1 when hi is not the sign-extension of lo[WIDTH-1].
REQ-022 For MULU, V SHALL be 1 when hi is nonzero.
REQ-023 For signed DIV, the quotient SHALL be negated when the signs differ, and the remainder SHALL take the dividend's sign.
REQ-024 For signed DIV of the most-negative value by -1: lo = most-negative, hi = 0, V = 1.
REQ-025 When S = 0 for DIV/DIVU: lo = all ones, hi = R, DZ = 1, V = 0.
REQ-026 N SHALL be hi[WIDTH-1] for MUL ops and lo[WIDTH-1] for DIV ops.
REQ-027 Z SHALL be 1 when {hi,lo} = 0 for MUL ops, or when lo = 0 for DIV ops.
REQ-028 N and V SHALL be 0 for unsigned ops, except MULU V per REQ-022.

Reset
REQ-029 reset_n low SHALL force state to IDLE at any time, including mid-CALC.
REQ-030 During reset, busy, done, hi, lo, N, Z, V, DZ and the counter SHALL all be 0.
REQ-031 Release SHALL require no start re-qualification; the first start after release SHALL be accepted normally.

Structure
REQ-032 Package muldiv_pkg SHALL hold the op encodings and the state encoding constants.
REQ-033 A combinational sub-module muldiv_step SHALL implement one MUL or DIV iteration on the accumulator.
REQ-034 Operand conditioning and sign fix SHALL stay in muldiv_seq.

Verification (WIDTH=64; also regress at WIDTH=8)
REQ-035 MUL R=-3, S=7 -> hi=FFFF_FFFF_FFFF_FFFF, lo=FFFF_FFFF_FFFF_FFEB, N=1, V=0, done exactly 66 clocks after start edge.
REQ-036 MULU R=S=FFFF_FFFF_FFFF_FFFF -> hi=FFFF_FFFF_FFFF_FFFE, lo=0000_0000_0000_0001, V=1.
REQ-037 DIV R=-7, S=2 -> lo=FFFF_FFFF_FFFF_FFFD (-3), hi=FFFF_FFFF_FFFF_FFFF (-1), N=1; DIVU R=100, S=7 -> lo=14, hi=2.
REQ-038 DIVU R=5, S=0 -> lo=all ones, hi=5, DZ=1 at 66 clocks; DIV R=8000_0000_0000_0000, S=-1 -> lo=8000_0000_0000_0000, hi=0, V=1.
REQ-039 Start DIV, pulse start again at clock 20, drop reset_n at clock 40 -> second start ignored; busy/done/hi/lo=0 immediately; new MUL 2x3 after release -> lo=6, hi=0.
REQ-040 Start asserted in the done cycle -> back-to-back op accepted; its done arrives 66 clocks later; prior hi/lo stable until then.
